// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_arbiter_pkg
//  Shared definitions for the IF/MEM memory arbiter: FSM state encoding,
//  owner tags, default widths and the starvation counter width helper.
//  No ports (package).
package riscv_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  // Counter must hold STARVE_LIMIT itself; never narrower than 3 bits.
  function automatic int starve_cnt_w(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/riscv_starve_ctr.sv
// riscv_starve_ctr
//  Counts data grants issued while a fetch is waiting. Once the count reaches
//  STARVE_LIMIT, force_if_o tells the arbiter to hand the next IDLE slot to
//  fetch. The count clears when fetch is granted or stops requesting.
// Ports
//  clock, reset_n  : clock, synchronous active-low reset
//  dm_grant_i      : data request granted this cycle
//  if_grant_i      : fetch request granted this cycle
//  if_pending_i    : fetch request is asserted
//  force_if_o      : fetch must win the next arbitration
module riscv_starve_ctr
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic dm_grant_i,
  input  logic if_grant_i,
  input  logic if_pending_i,
  output logic force_if_o
);

  localparam int              CW    = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_grant_i || !if_pending_i) begin
      cnt_d = '0;
    end else if (dm_grant_i && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign force_if_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//  Shares one single-ported memory between the IF (fetch) and MEM (load/store)
//  stages, one transaction in flight. FSM: IDLE -> ISSUE -> (WAIT) -> RESP.
//  Data requests win over fetch; a fetch may be killed by a flush, in which
//  case the memory access still completes but no if_done is produced.
// Configuration
//  RISCV_MEM_STARVE_GUARD_EN : when defined, riscv_starve_ctr forces a fetch
//  grant after STARVE_LIMIT consecutive data grants with fetch pending.
// Ports
//  clock, reset_n                 : clock, synchronous active-low reset
//  if_req/if_addr/if_kill         : fetch request, address, flush
//  if_done/if_rdata               : fetch completion pulse and data
//  dm_req/dm_we/dm_be/dm_addr/dm_wdata : data request and payload
//  dm_done/dm_rdata               : data completion pulse and load data
//  mem_req/mem_we/mem_be/mem_addr/mem_wdata : registered memory request
//  mem_ready/mem_rvalid/mem_rdata : memory accept, read valid, read data
//  busy                           : FSM not in IDLE
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_kill,
  output logic                    if_done,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  output logic                    dm_done,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int BW = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    kill_q, kill_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [BW-1:0]           mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;

  logic if_elig, force_if, grant_dm, grant_if, kill_now;

  // A fetch that is being flushed in the same cycle is not worth starting.
  assign if_elig  = if_req & ~if_kill;
  assign grant_dm = (state_q == ST_IDLE) & dm_req & ~(force_if & if_elig);
  assign grant_if = (state_q == ST_IDLE) & if_elig & (~dm_req | force_if);
  assign kill_now = if_kill & (owner_q == OWNER_IF);

`ifdef RISCV_MEM_STARVE_GUARD_EN
  riscv_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock        (clock),
    .reset_n      (reset_n),
    .dm_grant_i   (grant_dm),
    .if_grant_i   (grant_if),
    .if_pending_i (if_req),
    .force_if_o   (force_if)
  );
`else
  // Pure data priority: fetch can be starved by a continuous data stream.
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_dm) begin
          owner_d     = OWNER_DM;
          kill_d      = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_be_d    = dm_be;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = ST_ISSUE;
        end else if (grant_if) begin
          owner_d     = OWNER_IF;
          kill_d      = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (kill_now) kill_d = 1'b1;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (kill_now) kill_d = 1'b1;
        if (mem_rvalid) begin
          // Killed fetch data is consumed from memory but never exposed.
          if (owner_q == OWNER_DM)         dm_rdata_d = mem_rdata;
          else if (!(kill_q || kill_now))  if_rdata_d = mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_IF;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_done   = (state_q == ST_RESP) & (owner_q == OWNER_IF) & ~kill_q;
  assign dm_done   = (state_q == ST_RESP) & (owner_q == OWNER_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
//  Scoreboard bench: stimulus pushes expected completions and expected memory
//  requests; a done monitor and a memory model pop and compare independently.
module tb_riscv_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req, if_kill, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid, busy;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  riscv_mem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct { bit dm; bit has_data; logic [31:0] data; int at; } exp_t;
  typedef struct { bit we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } mexp_t;

  exp_t        exp_q[$];
  mexp_t       mexp_q[$];
  logic [31:0] mem_arr [logic [31:0]];
  int          rv_delay  = 1;
  int          rdy_delay = 0;
  int          checks = 0, errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_done(input bit dm, input bit has_data, input logic [31:0] d, input int at);
    exp_t e;
    e.dm = dm; e.has_data = has_data; e.data = d; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic push_mem(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    mexp_t m;
    m.we = we; m.be = be; m.addr = a; m.wdata = wd;
    mexp_q.push_back(m);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Done monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (if_done || dm_done) begin
        check32("done_exclusive", {31'b0, if_done & dm_done}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: if_done=%0b dm_done=%0b, none expected (cycle %0d)",
                   if_done, dm_done, cyc);
        end else begin
          e = exp_q.pop_front();
          check32("done_owner_dm", {31'b0, dm_done}, {31'b0, e.dm});
          if (e.has_data) check32("rdata", e.dm ? dm_rdata : if_rdata, e.data);
          if (e.at >= 0)  check32("done_cycle", cyc, e.at);
        end
      end
    end
  end

  // Memory model: configurable accept delay and read-data delay
  initial begin
    int          rd_cnt;
    int          wcnt;
    logic [31:0] rd_data, w;
    mexp_t       m;
    rd_cnt = 0; wcnt = 0; rd_data = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rd_data; end
      end
      mem_ready = 1'b0;
      if (mem_req) begin
        if (wcnt >= rdy_delay) begin
          mem_ready = 1'b1;
          wcnt = 0;
          if (mexp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: addr 0x%08h we %0b (cycle %0d)", mem_addr, mem_we, cyc);
          end else begin
            m = mexp_q.pop_front();
            check32("mem_we", {31'b0, mem_we}, {31'b0, m.we});
            check32("mem_addr", mem_addr, m.addr);
            if (m.we) begin
              check32("mem_be", {28'b0, mem_be}, {28'b0, m.be});
              check32("mem_wdata", mem_wdata, m.wdata);
            end
          end
          w = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
          if (mem_we) begin
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_arr[mem_addr] = w;
          end else begin
            rd_cnt  = rv_delay;
            rd_data = w;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    bit got;
    got = 0;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (if_done) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: no if_done for addr 0x%08h", a);
    end
    @(posedge clock); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_op(input bit we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input bit keep);
    bit got;
    got = 0;
    dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = a; dm_wdata = wd;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (dm_done) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL dm_timeout: no dm_done for addr 0x%08h", a);
    end
    @(posedge clock); #1;
    if (!keep) dm_req = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    if_req = 0; if_kill = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    mem_arr[32'h10]  = 32'h0000_0093;
    mem_arr[32'h100] = 32'h1122_3344;
    mem_arr[32'h104] = 32'h5566_7788;
    mem_arr[32'h200] = 32'h0000_0013;

    // Reset state
    tick(3);
    check32("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check32("rst_busy", {31'b0, busy}, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_if_rdata", if_rdata, 32'd0);
    check32("rst_dm_rdata", dm_rdata, 32'd0);
    reset_n = 1'b1;
    tick(1);

    // T1 fetch only: done 3 cycles after request
    n = cyc;
    push_mem(0, 4'h0, 32'h10, 32'h0);
    push_done(0, 1, 32'h0000_0093, n + 3);
    fetch(32'h10);
    tick(1);

    // T2 store: done 2 cycles after request, exact payload
    n = cyc;
    push_mem(1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    push_done(1, 0, 32'h0, n + 2);
    dm_op(1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 0);

    // Store with memory accepting 2 cycles late: done at n+4
    rdy_delay = 2;
    n = cyc;
    push_mem(1, 4'b1100, 32'h104, 32'hCAFE_0000);
    push_done(1, 0, 32'h0, n + 4);
    dm_op(1, 4'b1100, 32'h104, 32'hCAFE_0000, 0);
    rdy_delay = 0;
    tick(1);

    // T3 contention: load wins, fetch follows in next IDLE
    n = cyc;
    push_mem(0, 4'h0, 32'h100, 32'h0);
    push_mem(0, 4'h0, 32'h200, 32'h0);
    push_done(1, 1, 32'h1122_BEEF, n + 3);
    push_done(0, 1, 32'h0000_0013, n + 7);
    fork
      fetch(32'h200);
      dm_op(0, 4'hF, 32'h100, 32'h0, 0);
    join
    n = cyc;
    push_mem(0, 4'h0, 32'h104, 32'h0);
    push_done(1, 1, 32'hCAFE_7788, n + 3);
    dm_op(0, 4'hF, 32'h104, 32'h0, 0);
    tick(1);

    // Fetch with kill asserted in IDLE is not eligible
    if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h10;
    tick(1);
    check32("kill_idle_mem_req", {31'b0, mem_req}, 32'd0);
    check32("kill_idle_busy", {31'b0, busy}, 32'd0);
    if_req = 1'b0; if_kill = 1'b0;
    tick(1);

    // T4 kill during WAIT: no if_done, back to IDLE after RESP
    rv_delay = 3;
    push_mem(0, 4'h0, 32'h10, 32'h0);
    if_req = 1'b1; if_addr = 32'h10;
    tick(2);
    if_kill = 1'b1;
    tick(1);
    if_kill = 1'b0; if_req = 1'b0;
    check32("kill_wait_busy", {31'b0, busy}, 32'd1);
    tick(3);
    check32("kill_end_busy", {31'b0, busy}, 32'd0);
    rv_delay = 1;
    n = cyc;
    push_mem(0, 4'h0, 32'h200, 32'h0);
    push_done(0, 1, 32'h0000_0013, n + 3);
    fetch(32'h200);
    tick(1);

    // T5 reset mid-WAIT: late rvalid must not produce a done
    rv_delay = 3;
    push_mem(0, 4'h0, 32'h104, 32'h0);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    tick(2);
    reset_n = 1'b0; dm_req = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check32("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
    check32("rst_mid_busy", {31'b0, busy}, 32'd0);
    check32("rst_mid_dm_rdata", dm_rdata, 32'd0);
    tick(4);
    check32("rst_late_busy", {31'b0, busy}, 32'd0);
    rv_delay = 1;

    // T6 continuous data stream with fetch held
`ifdef RISCV_MEM_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) begin
      push_mem(0, 4'h0, 32'h100, 32'h0);
      push_done(1, 1, 32'h1122_BEEF, -1);
    end
    push_mem(0, 4'h0, 32'h10, 32'h0);
    push_done(0, 1, 32'h0000_0093, -1);
    for (int k = 0; k < 2; k++) begin
      push_mem(0, 4'h0, 32'h100, 32'h0);
      push_done(1, 1, 32'h1122_BEEF, -1);
    end
`else
    for (int k = 0; k < 6; k++) begin
      push_mem(0, 4'h0, 32'h100, 32'h0);
      push_done(1, 1, 32'h1122_BEEF, -1);
    end
    push_mem(0, 4'h0, 32'h10, 32'h0);
    push_done(0, 1, 32'h0000_0093, -1);
`endif
    fork
      fetch(32'h10);
      begin
        for (int k = 0; k < 6; k++) dm_op(0, 4'hF, 32'h100, 32'h0, k < 5);
      end
    join

    // Drain
    for (int i = 0; i < 50 && (exp_q.size() != 0 || mexp_q.size() != 0); i++) tick(1);
    if (exp_q.size() != 0 || mexp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d done and %0d mem expectations left, 0 required",
               exp_q.size(), mexp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
